game_core_param: RTL and testbench

GAME_CORE_PARAM -- requirements
Module: game_core_param

---
 rtl/game_core_param.sv | 100 ++++++++++
 tb/tb_game_core_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_core_param.sv
// game_core_param: lights-out puzzle core with one-deep undo, optional step limit and LFSR board scrambling
module game_core_param #(
  parameter int N_BTN     = 12,
  parameter int STEP_W    = 14,
  parameter int MAX_STEPS = 0
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic              start_sw,
  input  logic [N_BTN-1:0]  act_bt,
  input  logic              undo_bt,
  input  logic              random_sw,
  input  logic [N_BTN-1:0]  board_init,
  output logic [N_BTN-1:0]  board,
  output logic [2:0]        game_status,
  output logic [STEP_W-1:0] step_number,
  output logic              timer_en,
  output logic              win_flag,
  output logic              lose_flag
);
  typedef enum logic [2:0] {IDLE = 3'b000, INIT = 3'b001, PLAY = 3'b010, WON = 3'b011, LOST = 3'b100} state_t;
  state_t r_state, w_next;
  logic [N_BTN-1:0] r_board, r_hist, r_act_q, w_act_edge, w_low, w_mask, w_board_nxt, w_hist_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [15:0] r_lfsr;
  logic r_hist_valid, r_start_q, r_undo_q, w_hist_valid_nxt, w_start_edge, w_undo_edge, w_limit;
  assign w_start_edge = start_sw & ~r_start_q;
  assign w_undo_edge  = undo_bt & ~r_undo_q;
  assign w_act_edge   = act_bt & ~r_act_q;
  // Isolate the lowest pressed button; shifts drop neighbours beyond the board edges.
  assign w_low   = w_act_edge & (~w_act_edge + 1'b1);
  assign w_mask  = w_low | (w_low << 1) | (w_low >> 1);
  assign w_limit = (MAX_STEPS != 0) && (32'(r_step) >= 32'(MAX_STEPS));
  // A move in PLAY pre-empts the end-of-game checks so a game may start from an empty board.
  always_comb begin
    w_next           = r_state;
    w_board_nxt      = r_board;
    w_step_nxt       = r_step;
    w_hist_nxt       = r_hist;
    w_hist_valid_nxt = r_hist_valid;
    case (r_state)
      IDLE: begin
        w_board_nxt = board_init;
        w_step_nxt  = '0;
        w_next      = w_start_edge ? INIT : IDLE;
      end
      INIT: begin
        w_board_nxt      = board_init ^ (random_sw ? r_lfsr[N_BTN-1:0] : '0);
        w_step_nxt       = '0;
        w_hist_valid_nxt = 1'b0;
        w_next           = PLAY;
      end
      PLAY: begin
        if (!start_sw) w_next = IDLE;
        else if (|w_act_edge) begin
          w_hist_nxt       = r_board;
          w_hist_valid_nxt = 1'b1;
          w_board_nxt      = r_board ^ w_mask;
          w_step_nxt       = &r_step ? r_step : r_step + 1'b1;
        end else if (r_board == '0) w_next = WON;
        else if (w_limit) w_next = LOST;
        else if (w_undo_edge && r_hist_valid) begin
          w_board_nxt      = r_hist;
          w_hist_valid_nxt = 1'b0;
          w_step_nxt       = (r_step != '0) ? r_step - 1'b1 : r_step;
        end
      end
      default: w_next = start_sw ? r_state : IDLE;
    endcase
  end
  always_ff @(posedge clk_d) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_board      <= '0;
      r_step       <= '0;
      r_hist       <= '0;
      r_hist_valid <= 1'b0;
      r_lfsr       <= 16'hACE1;
      r_start_q    <= 1'b0;
      r_undo_q     <= 1'b0;
      r_act_q      <= '0;
    end else begin
      r_state      <= w_next;
      r_board      <= w_board_nxt;
      r_step       <= w_step_nxt;
      r_hist       <= w_hist_nxt;
      r_hist_valid <= w_hist_valid_nxt;
      r_lfsr       <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
      r_start_q    <= start_sw;
      r_undo_q     <= undo_bt;
      r_act_q      <= act_bt;
    end
  end
  assign board       = r_board;
  assign game_status = r_state;
  assign step_number = r_step;
  assign timer_en    = (r_state == PLAY);
  assign win_flag    = (r_state == WON);
  assign lose_flag   = (r_state == LOST);
endmodule

// File: tb/tb_game_core_param.sv
// tb_game_core_param: directed scenarios plus randomized play against a behavioural game model
module tb_game_core_param;
  localparam int N = 12;
  localparam int SW = 14;
  logic clk_d = 1'b0, rst = 1'b0, start_sw = 1'b0, undo_bt = 1'b0, random_sw = 1'b0;
  logic [N-1:0] act_bt = '0, board_init = '0;
  logic [N-1:0] board, board_l;
  logic [2:0] gs, gs_l;
  logic [SW-1:0] step, step_l;
  logic te, te_l, wf, wf_l, lf, lf_l;
  int checks = 0, failures = 0;
  int m_st[2] = '{0, 0};
  int m_stp[2] = '{0, 0};
  int m_max[2] = '{0, 2};
  bit m_hv[2] = '{0, 0};
  logic [N-1:0] m_brd[2] = '{'0, '0};
  logic [N-1:0] m_hist[2] = '{'0, '0};
  logic [15:0] m_lfsr = 16'hACE1;
  logic p_start = 1'b0, p_undo = 1'b0;
  logic [N-1:0] p_act = '0;

  always #5 clk_d = ~clk_d;

  game_core_param dut (.clk_d(clk_d), .rst(rst), .start_sw(start_sw), .act_bt(act_bt), .undo_bt(undo_bt),
    .random_sw(random_sw), .board_init(board_init), .board(board), .game_status(gs), .step_number(step),
    .timer_en(te), .win_flag(wf), .lose_flag(lf));
  game_core_param #(.MAX_STEPS(2)) lim (.clk_d(clk_d), .rst(rst), .start_sw(start_sw), .act_bt(act_bt),
    .undo_bt(undo_bt), .random_sw(random_sw), .board_init(board_init), .board(board_l), .game_status(gs_l),
    .step_number(step_l), .timer_en(te_l), .win_flag(wf_l), .lose_flag(lf_l));

  // Advance the game model by one clock using the current inputs, then clock both DUTs.
  task automatic cycle();
    logic [N-1:0] ae, mask;
    bit se, ue;
    int lo;
    se = start_sw && !p_start;
    ue = undo_bt && !p_undo;
    ae = act_bt & ~p_act;
    lo = -1;
    for (int i = N - 1; i >= 0; i--) if (ae[i]) lo = i;
    mask = '0;
    for (int j = lo - 1; j <= lo + 1; j++) if (lo >= 0 && j >= 0 && j < N) mask[j] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_st[k] = 0; m_brd[k] = '0; m_hist[k] = '0; m_stp[k] = 0; m_hv[k] = 0;
      end else case (m_st[k])
        0: begin m_brd[k] = board_init; m_stp[k] = 0; if (se) m_st[k] = 1; end
        1: begin m_brd[k] = board_init ^ (random_sw ? m_lfsr[N-1:0] : '0); m_stp[k] = 0; m_hv[k] = 0; m_st[k] = 2; end
        2: begin
          if (!start_sw) m_st[k] = 0;
          else if (lo >= 0) begin
            m_hist[k] = m_brd[k]; m_hv[k] = 1; m_brd[k] ^= mask;
            m_stp[k] = (m_stp[k] >= (1 << SW) - 1) ? (1 << SW) - 1 : m_stp[k] + 1;
          end else if (m_brd[k] == '0) m_st[k] = 3;
          else if (m_max[k] != 0 && m_stp[k] >= m_max[k]) m_st[k] = 4;
          else if (ue && m_hv[k]) begin
            m_brd[k] = m_hist[k]; m_hv[k] = 0; m_stp[k] = (m_stp[k] > 0) ? m_stp[k] - 1 : 0;
          end
        end
        default: if (!start_sw) m_st[k] = 0;
      endcase
    end
    if (!rst) begin
      m_lfsr = 16'hACE1; p_start = 1'b0; p_undo = 1'b0; p_act = '0;
    end else begin
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hD008)};
      p_start = start_sw; p_undo = undo_bt; p_act = act_bt;
    end
    @(posedge clk_d);
    #1;
  endtask

  task automatic start_game(input logic [N-1:0] init);
    act_bt = '0; undo_bt = 1'b0; random_sw = 1'b0; start_sw = 1'b0;
    cycle();
    board_init = init; start_sw = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; start_sw = 1'b0; board_init = 12'h3A5;
    cycle(); cycle();
    checks++; if (gs !== 3'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", gs); end
    checks++; if (board !== '0 || step !== '0) begin failures++; $display("FAIL reset_regs board=%h step=%0d exp 000/0", board, step); end
    checks++; if ({te, wf, lf} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {te, wf, lf}); end
    rst = 1'b1;
    cycle();
    checks++; if (gs !== 3'd0 || board !== 12'h3A5 || step !== '0) begin failures++; $display("FAIL idle_follow status=%0d board=%h step=%0d exp 0/3a5/0", gs, board, step); end
  endtask

  task automatic test_win();
    start_game(12'h007);
    checks++; if (gs !== 3'd2 || board !== 12'h007 || te !== 1'b1) begin failures++; $display("FAIL win_start status=%0d board=%h te=%b exp 2/007/1", gs, board, te); end
    act_bt = 12'h002;
    cycle();
    checks++; if (board !== 12'h000 || step !== 14'd1 || gs !== 3'd2) begin failures++; $display("FAIL win_move board=%h step=%0d status=%0d exp 000/1/2", board, step, gs); end
    act_bt = '0;
    cycle();
    checks++; if (gs !== 3'd3 || {te, wf, lf} !== 3'b010) begin failures++; $display("FAIL win_state status=%0d flags=%b exp 3/010", gs, {te, wf, lf}); end
    act_bt = 12'h100;
    cycle();
    checks++; if (board !== 12'h000 || step !== 14'd1) begin failures++; $display("FAIL win_frozen board=%h step=%0d exp 000/1", board, step); end
    start_sw = 1'b0; act_bt = '0;
    cycle();
    checks++; if (gs !== 3'd0 || wf !== 1'b0) begin failures++; $display("FAIL win_exit status=%0d wf=%b exp 0/0", gs, wf); end
  endtask

  task automatic test_clip();
    start_game(12'h000);
    act_bt = 12'h001;
    cycle();
    checks++; if (board !== 12'h003 || step !== 14'd1 || gs !== 3'd2) begin failures++; $display("FAIL clip_low board=%h step=%0d status=%0d exp 003/1/2", board, step, gs); end
    cycle();
    checks++; if (board !== 12'h003 || step !== 14'd1) begin failures++; $display("FAIL held_level board=%h step=%0d exp 003/1", board, step); end
    act_bt = 12'h800;
    cycle();
    checks++; if (board !== 12'hC03 || step !== 14'd2) begin failures++; $display("FAIL clip_high board=%h step=%0d exp c03/2", board, step); end
    act_bt = '0; start_sw = 1'b0;
    cycle();
  endtask

  task automatic test_undo();
    start_game(12'h0F0);
    act_bt = 12'h020;
    cycle();
    checks++; if (board !== 12'h080 || step !== 14'd1) begin failures++; $display("FAIL undo_move board=%h step=%0d exp 080/1", board, step); end
    act_bt = '0;
    cycle();
    undo_bt = 1'b1;
    cycle();
    checks++; if (board !== 12'h0F0 || step !== 14'd0) begin failures++; $display("FAIL undo_restore board=%h step=%0d exp 0f0/0", board, step); end
    undo_bt = 1'b0;
    cycle();
    undo_bt = 1'b1;
    cycle();
    checks++; if (board !== 12'h0F0 || step !== 14'd0 || gs !== 3'd2) begin failures++; $display("FAIL undo_twice board=%h step=%0d status=%0d exp 0f0/0/2", board, step, gs); end
    undo_bt = 1'b0;
    cycle();
    act_bt = 12'h020; undo_bt = 1'b1;
    cycle();
    checks++; if (board !== 12'h080 || step !== 14'd1) begin failures++; $display("FAIL undo_vs_act board=%h step=%0d exp 080/1", board, step); end
    act_bt = '0; undo_bt = 1'b0;
    cycle();
    undo_bt = 1'b1;
    cycle();
    checks++; if (board !== 12'h0F0 || step !== 14'd0) begin failures++; $display("FAIL undo_after_tie board=%h step=%0d exp 0f0/0", board, step); end
    undo_bt = 1'b0; start_sw = 1'b0;
    cycle();
  endtask

  task automatic test_multi();
    start_game(12'h000);
    act_bt = 12'h088;
    cycle();
    checks++; if (board !== 12'h01C || step !== 14'd1) begin failures++; $display("FAIL multi_press board=%h step=%0d exp 01c/1", board, step); end
    act_bt = '0; start_sw = 1'b0;
    cycle();
  endtask

  task automatic test_lose();
    start_game(12'h800);
    for (int n = 0; n < 2; n++) begin
      act_bt = 12'h001;
      cycle();
      act_bt = '0;
      cycle();
    end
    checks++; if (board_l !== 12'h800 || step_l !== 14'd2) begin failures++; $display("FAIL lose_regs board=%h step=%0d exp 800/2", board_l, step_l); end
    checks++; if (gs_l !== 3'd4 || {te_l, wf_l, lf_l} !== 3'b001) begin failures++; $display("FAIL lose_state status=%0d flags=%b exp 4/001", gs_l, {te_l, wf_l, lf_l}); end
    checks++; if (gs !== 3'd2) begin failures++; $display("FAIL unlimited_play status=%0d exp 2", gs); end
    act_bt = 12'h001;
    cycle();
    checks++; if (board_l !== 12'h800 || step_l !== 14'd2) begin failures++; $display("FAIL lose_frozen board=%h step=%0d exp 800/2", board_l, step_l); end
    act_bt = '0; start_sw = 1'b0;
    cycle();
    checks++; if (gs_l !== 3'd0 || lf_l !== 1'b0) begin failures++; $display("FAIL lose_exit status=%0d lf=%b exp 0/0", gs_l, lf_l); end
  endtask

  task automatic test_mid_reset();
    start_game(12'h555);
    for (int n = 0; n < 5; n++) begin
      act_bt = 12'h004;
      cycle();
      act_bt = '0;
      cycle();
    end
    checks++; if (step !== 14'd5 || gs !== 3'd2) begin failures++; $display("FAIL pre_reset step=%0d status=%0d exp 5/2", step, gs); end
    rst = 1'b0;
    cycle();
    checks++; if (gs !== 3'd0 || board !== '0 || step !== '0 || {te, wf, lf} !== 3'b000) begin failures++; $display("FAIL mid_reset status=%0d board=%h step=%0d flags=%b exp 0/000/0/000", gs, board, step, {te, wf, lf}); end
    rst = 1'b1;
    cycle();
    checks++; if (gs !== 3'd1) begin failures++; $display("FAIL start_held_reset status=%0d exp 1", gs); end
    cycle();
    checks++; if (gs !== 3'd2 || board !== 12'h555 || step !== '0) begin failures++; $display("FAIL restart_play status=%0d board=%h step=%0d exp 2/555/0", gs, board, step); end
    start_sw = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) != 0);
      start_sw = ($urandom_range(0, 24) != 0);
      r = $urandom_range(0, 3);
      act_bt = (r == 0) ? N'($urandom) & N'($urandom) : (r == 1) ? '0 : act_bt;
      undo_bt = ($urandom_range(0, 2) == 0);
      random_sw = 1'($urandom);
      board_init = $urandom_range(0, 1) ? N'($urandom) : N'(3 << $urandom_range(0, N - 1));
      cycle();
      checks++; if (gs !== 3'(m_st[0]) || board !== m_brd[0] || step !== SW'(m_stp[0]) || {te, wf, lf} !== {m_st[0] == 2, m_st[0] == 3, m_st[0] == 4}) begin
        failures++; $display("FAIL random_dut cycle=%0d status=%0d board=%h step=%0d flags=%b exp status=%0d board=%h step=%0d", c, gs, board, step, {te, wf, lf}, m_st[0], m_brd[0], m_stp[0]);
      end
      checks++; if (gs_l !== 3'(m_st[1]) || board_l !== m_brd[1] || step_l !== SW'(m_stp[1]) || {te_l, wf_l, lf_l} !== {m_st[1] == 2, m_st[1] == 3, m_st[1] == 4}) begin
        failures++; $display("FAIL random_lim cycle=%0d status=%0d board=%h step=%0d flags=%b exp status=%0d board=%h step=%0d", c, gs_l, board_l, step_l, {te_l, wf_l, lf_l}, m_st[1], m_brd[1], m_stp[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_clip();
    test_undo();
    test_multi();
    test_lose();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
